// File: rtl/dma_burst_sequencer_if.sv
// Command/status bundle between the DMA config registers, the burst sequencer
// and the DMA master datapath.
interface dma_burst_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 32
);
  logic              cfg_en;
  logic [ADDR_W-1:0] cfg_src;
  logic [ADDR_W-1:0] cfg_dst;
  logic [LEN_W-1:0]  cfg_len;

  // Commands use valid/ready: valid, addr and len hold steady until the
  // cycle ready is seen high with valid; the transfer happens on that edge.
  logic              rd_cmd_valid;
  logic              rd_cmd_ready;
  logic [ADDR_W-1:0] rd_cmd_addr;
  logic [3:0]        rd_cmd_len;
  logic              rd_done;

  logic              wr_cmd_valid;
  logic              wr_cmd_ready;
  logic [ADDR_W-1:0] wr_cmd_addr;
  logic [3:0]        wr_cmd_len;
  logic              wr_done;
  logic              wr_resp_err;

  logic              busy;
  logic              dma_interrupt;
  logic              err;
  logic [2:0]        dbg_state;

  modport master (
    input  cfg_en, cfg_src, cfg_dst, cfg_len,
    input  rd_cmd_ready, rd_done, wr_cmd_ready, wr_done, wr_resp_err,
    output rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
    output wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
    output busy, dma_interrupt, err, dbg_state
  );

  modport slave (
    output cfg_en, cfg_src, cfg_dst, cfg_len,
    output rd_cmd_ready, rd_done, wr_cmd_ready, wr_done, wr_resp_err,
    input  rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
    input  wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
    input  busy, dma_interrupt, err, dbg_state
  );
endinterface

// File: rtl/dma_burst_sequencer.sv
// Splits a word-count memory copy into read-then-write bursts of at most
// MAX_BURST beats that never cross a 4 KB page on source or destination.
module dma_burst_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  dma_burst_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CALC    = 3'd1,
    S_RD_CMD  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_WR_CMD  = 3'd4,
    S_WR_WAIT = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [4:0] MAX_BEATS = 5'(MAX_BURST);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_rem;
  logic [4:0]        r_beats;
  logic              r_err;

  logic [10:0]       w_src_room;
  logic [10:0]       w_dst_room;
  logic [4:0]        w_rem_cap;
  logic [4:0]        w_src_cap;
  logic [4:0]        w_dst_cap;
  logic [4:0]        w_beats;
  logic [3:0]        w_len;
  logic              w_rd_valid;
  logic              w_wr_valid;

  // Words left before the next 4 KB page, each clamped to MAX_BURST so the
  // minimum fits in five bits.
  assign w_src_room = 11'd1024 - {1'b0, r_src[11:2]};
  assign w_dst_room = 11'd1024 - {1'b0, r_dst[11:2]};
  assign w_rem_cap  = (r_rem > LEN_W'(MAX_BURST))       ? MAX_BEATS : r_rem[4:0];
  assign w_src_cap  = (w_src_room > 11'(MAX_BURST))     ? MAX_BEATS : w_src_room[4:0];
  assign w_dst_cap  = (w_dst_room > 11'(MAX_BURST))     ? MAX_BEATS : w_dst_room[4:0];

  always_comb begin
    w_beats = w_rem_cap;
    if (w_src_cap < w_beats) w_beats = w_src_cap;
    if (w_dst_cap < w_beats) w_beats = w_dst_cap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.cfg_en) w_next = (bus.cfg_len == '0) ? S_DONE : S_CALC;
      S_CALC:    w_next = S_RD_CMD;
      S_RD_CMD:  if (bus.rd_cmd_ready) w_next = S_RD_WAIT;
      S_RD_WAIT: if (bus.rd_done) w_next = S_WR_CMD;
      S_WR_CMD:  if (bus.wr_cmd_ready) w_next = S_WR_WAIT;
      S_WR_WAIT: begin
        if (bus.wr_done) begin
          if (bus.wr_resp_err)              w_next = S_DONE;
          else if (!bus.cfg_en)             w_next = S_IDLE;
          else if (r_rem == LEN_W'(r_beats)) w_next = S_DONE;
          else                              w_next = S_CALC;
        end
      end
      S_DONE:    if (!bus.cfg_en) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_beats <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && bus.cfg_en) begin
        r_src <= bus.cfg_src;
        r_dst <= bus.cfg_dst;
        r_rem <= bus.cfg_len;
        r_err <= 1'b0;
      end
      if (r_state == S_CALC) r_beats <= w_beats;
      // A clean completion with DMAEN dropped abandons the copy without advancing.
      if (r_state == S_WR_WAIT && bus.wr_done) begin
        if (bus.wr_resp_err) begin
          r_err <= 1'b1;
        end else if (bus.cfg_en) begin
          r_src <= r_src + ADDR_W'({r_beats, 2'b00});
          r_dst <= r_dst + ADDR_W'({r_beats, 2'b00});
          r_rem <= r_rem - LEN_W'(r_beats);
        end
      end
    end
  end

  // beats of 16 wraps to 4'hF, which is exactly the AXI len encoding.
  assign w_len      = r_beats[3:0] - 4'd1;
  assign w_rd_valid = (r_state == S_RD_CMD);
  assign w_wr_valid = (r_state == S_WR_CMD);

  assign bus.rd_cmd_valid  = w_rd_valid;
  assign bus.rd_cmd_addr   = w_rd_valid ? r_src : '0;
  assign bus.rd_cmd_len    = w_rd_valid ? w_len : 4'd0;
  assign bus.wr_cmd_valid  = w_wr_valid;
  assign bus.wr_cmd_addr   = w_wr_valid ? r_dst : '0;
  assign bus.wr_cmd_len    = w_wr_valid ? w_len : 4'd0;
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.dma_interrupt = (r_state == S_DONE);
  assign bus.err           = r_err;
  assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_dma_burst_sequencer.sv
// Directed bench for dma_burst_sequencer: a datapath responder/monitor plus
// one task per scenario with inline expected-value checks.
module tb_dma_burst_sequencer;

  localparam int ADDR_W    = 32;
  localparam int LEN_W     = 32;
  localparam int MAX_BURST = 16;
  localparam int W         = 1 + ADDR_W + 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CALC    = 3'd1;
  localparam logic [2:0] ST_RD_CMD  = 3'd2;
  localparam logic [2:0] ST_WR_WAIT = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   err_inject = 1'b0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;

  // Expected command stream: {is_write, addr, len}
  logic [W-1:0] exp_q[$];

  dma_burst_sequencer_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  dma_burst_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] cmd(input bit wr, input logic [ADDR_W-1:0] a, input logic [3:0] l);
    return {wr, a, l};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // ---------------- datapath responder + command monitor ----------------
  initial begin : responder
    logic [W-1:0] act;
    logic [W-1:0] exp_v;
    bit           have;
    bus.rd_done     = 1'b0;
    bus.wr_done     = 1'b0;
    bus.wr_resp_err = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      bus.rd_done     = 1'b0;
      bus.wr_done     = 1'b0;
      bus.wr_resp_err = 1'b0;
      have            = 1'b0;
      act             = '0;
      if (rst) begin
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0) bus.rd_done = 1'b1;
        end
        if (wr_cnt > 0) begin
          wr_cnt--;
          if (wr_cnt == 0) begin
            bus.wr_done     = 1'b1;
            bus.wr_resp_err = err_inject;
          end
        end
        if (bus.rd_cmd_valid && bus.rd_cmd_ready) begin
          act = {1'b0, bus.rd_cmd_addr, bus.rd_cmd_len};
          have = 1'b1;
          rd_cnt = 3;
        end
        if (bus.wr_cmd_valid && bus.wr_cmd_ready) begin
          act = {1'b1, bus.wr_cmd_addr, bus.wr_cmd_len};
          have = 1'b1;
          wr_cnt = 3;
        end
        if (have) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL cmd_unexpected: got wr=%0d addr=%h len=%0d, required no command",
                     act[W-1], act[W-2:4], act[3:0]);
          end else begin
            exp_v = exp_q.pop_front();
            if (act !== exp_v) begin
              errors++;
              $display("FAIL cmd_seq: got wr=%0d addr=%h len=%0d, required wr=%0d addr=%h len=%0d",
                       act[W-1], act[W-2:4], act[3:0], exp_v[W-1], exp_v[W-2:4], exp_v[3:0]);
            end
          end
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0)          begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    checks++; if (bus.dma_interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b required 0", bus.dma_interrupt); end
    checks++; if (bus.rd_cmd_valid !== 1'b0)  begin errors++; $display("FAIL reset_rd_valid: got %b required 0", bus.rd_cmd_valid); end
    checks++; if (bus.wr_cmd_valid !== 1'b0)  begin errors++; $display("FAIL reset_wr_valid: got %b required 0", bus.wr_cmd_valid); end
    checks++; if (bus.err !== 1'b0)           begin errors++; $display("FAIL reset_err: got %b required 0", bus.err); end
    checks++; if (bus.rd_cmd_addr !== '0 || bus.rd_cmd_len !== 4'd0) begin errors++; $display("FAIL reset_rd_cmd: got %h/%0d required 0/0", bus.rd_cmd_addr, bus.rd_cmd_len); end
    checks++; if (bus.dbg_state !== ST_IDLE)  begin errors++; $display("FAIL reset_state: got %0d required %0d", bus.dbg_state, ST_IDLE); end
    step();
    step();
    rst = 1'b0;
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b required 0", bus.busy); end
  endtask

  task automatic test_copy40();
    step();
    bus.cfg_src = 32'h0000_1000;
    bus.cfg_dst = 32'h0000_2000;
    bus.cfg_len = 32'd40;
    exp_q.push_back(cmd(1'b0, 32'h1000, 4'd15));
    exp_q.push_back(cmd(1'b1, 32'h2000, 4'd15));
    exp_q.push_back(cmd(1'b0, 32'h1040, 4'd15));
    exp_q.push_back(cmd(1'b1, 32'h2040, 4'd15));
    exp_q.push_back(cmd(1'b0, 32'h1080, 4'd7));
    exp_q.push_back(cmd(1'b1, 32'h2080, 4'd7));
    bus.cfg_en = 1'b1;
    step();
    checks++; if (bus.dbg_state !== ST_CALC) begin errors++; $display("FAIL copy_start_calc: got %0d required %0d", bus.dbg_state, ST_CALC); end
    // Changing cfg after start must not disturb the latched transfer.
    bus.cfg_src = 32'hDEAD_0000;
    bus.cfg_len = 32'd5;
    step();
    checks++; if (bus.rd_cmd_valid !== 1'b1) begin errors++; $display("FAIL copy_start_rd_valid: got %b required 1", bus.rd_cmd_valid); end
    for (int i = 0; i < 400 && !bus.dma_interrupt; i++) step();
    checks++; if (bus.dma_interrupt !== 1'b1) begin errors++; $display("FAIL copy_irq: got %b required 1", bus.dma_interrupt); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL copy_err: got %b required 0", bus.err); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL copy_cmds_left: got %0d pending required 0", exp_q.size()); end
    bus.cfg_en = 1'b0;
    step();
    checks++; if (bus.busy !== 1'b0 || bus.dma_interrupt !== 1'b0) begin errors++; $display("FAIL copy_ack: got busy=%b irq=%b required 0/0", bus.busy, bus.dma_interrupt); end
  endtask

  task automatic test_4k_split();
    step();
    bus.cfg_src = 32'h0000_1FF8;
    bus.cfg_dst = 32'h0000_3000;
    bus.cfg_len = 32'd8;
    exp_q.push_back(cmd(1'b0, 32'h1FF8, 4'd1));
    exp_q.push_back(cmd(1'b1, 32'h3000, 4'd1));
    exp_q.push_back(cmd(1'b0, 32'h2000, 4'd5));
    exp_q.push_back(cmd(1'b1, 32'h3008, 4'd5));
    bus.cfg_en = 1'b1;
    for (int i = 0; i < 100 && !bus.wr_done; i++) step();
    checks++; if (bus.dbg_state !== ST_CALC) begin errors++; $display("FAIL split_wrdone_calc: got %0d required %0d", bus.dbg_state, ST_CALC); end
    step();
    checks++; if (bus.rd_cmd_valid !== 1'b1 || bus.rd_cmd_addr !== 32'h2000) begin errors++; $display("FAIL split_next_rd: got v=%b addr=%h required 1/00002000", bus.rd_cmd_valid, bus.rd_cmd_addr); end
    for (int i = 0; i < 100 && !bus.wr_done; i++) step();
    checks++; if (bus.dma_interrupt !== 1'b1) begin errors++; $display("FAIL split_last_irq: got %b required 1", bus.dma_interrupt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL split_cmds_left: got %0d pending required 0", exp_q.size()); end
    bus.cfg_en = 1'b0;
    step();
  endtask

  task automatic test_zero_len();
    step();
    bus.cfg_src = 32'h0000_7000;
    bus.cfg_dst = 32'h0000_8000;
    bus.cfg_len = 32'd0;
    bus.cfg_en  = 1'b1;
    step();
    checks++; if (bus.dma_interrupt !== 1'b1) begin errors++; $display("FAIL zero_irq: got %b required 1", bus.dma_interrupt); end
    checks++; if (bus.dbg_state !== ST_DONE) begin errors++; $display("FAIL zero_state: got %0d required %0d", bus.dbg_state, ST_DONE); end
    step();
    step();
    checks++; if (bus.rd_cmd_valid !== 1'b0 || bus.wr_cmd_valid !== 1'b0) begin errors++; $display("FAIL zero_valids: got rd=%b wr=%b required 0/0", bus.rd_cmd_valid, bus.wr_cmd_valid); end
    checks++; if (bus.dma_interrupt !== 1'b1) begin errors++; $display("FAIL zero_irq_hold: got %b required 1", bus.dma_interrupt); end
    bus.cfg_en = 1'b0;
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL zero_busy_drop: got %b required 0", bus.busy); end
  endtask

  task automatic test_error_abort();
    step();
    bus.cfg_src = 32'h0000_1000;
    bus.cfg_dst = 32'h0000_2000;
    bus.cfg_len = 32'd40;
    err_inject  = 1'b1;
    exp_q.push_back(cmd(1'b0, 32'h1000, 4'd15));
    exp_q.push_back(cmd(1'b1, 32'h2000, 4'd15));
    bus.cfg_en = 1'b1;
    for (int i = 0; i < 200 && !bus.dma_interrupt; i++) step();
    checks++; if (bus.dma_interrupt !== 1'b1) begin errors++; $display("FAIL abort_irq: got %b required 1", bus.dma_interrupt); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL abort_err: got %b required 1", bus.err); end
    repeat (5) step();
    checks++; if (bus.rd_cmd_valid !== 1'b0 || bus.dbg_state !== ST_DONE) begin errors++; $display("FAIL abort_hold: got rd=%b state=%0d required 0/%0d", bus.rd_cmd_valid, bus.dbg_state, ST_DONE); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abort_cmds_left: got %0d pending required 0", exp_q.size()); end
    err_inject = 1'b0;
    bus.cfg_en = 1'b0;
    step();
    checks++; if (bus.busy !== 1'b0 || bus.err !== 1'b1) begin errors++; $display("FAIL abort_sticky: got busy=%b err=%b required 0/1", bus.busy, bus.err); end
    bus.cfg_src = 32'h0000_0000;
    bus.cfg_dst = 32'h0000_0100;
    bus.cfg_len = 32'd4;
    exp_q.push_back(cmd(1'b0, 32'h0000, 4'd3));
    exp_q.push_back(cmd(1'b1, 32'h0100, 4'd3));
    bus.cfg_en = 1'b1;
    step();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL abort_restart_err: got %b required 0", bus.err); end
    for (int i = 0; i < 200 && !bus.dma_interrupt; i++) step();
    checks++; if (bus.dma_interrupt !== 1'b1 || exp_q.size() != 0) begin errors++; $display("FAIL abort_restart_done: got irq=%b pending=%0d required 1/0", bus.dma_interrupt, exp_q.size()); end
    bus.cfg_en = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    step();
    bus.rd_cmd_ready = 1'b0;
    bus.wr_cmd_ready = 1'b0;
    bus.cfg_src = 32'h0000_4000;
    bus.cfg_dst = 32'h0000_5000;
    bus.cfg_len = 32'd4;
    exp_q.push_back(cmd(1'b0, 32'h4000, 4'd3));
    exp_q.push_back(cmd(1'b1, 32'h5000, 4'd3));
    bus.cfg_en = 1'b1;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.rd_cmd_valid !== 1'b1 || bus.rd_cmd_addr !== 32'h4000 || bus.rd_cmd_len !== 4'd3) begin
        errors++; $display("FAIL bp_rd_stable: cycle %0d got v=%b addr=%h len=%0d required 1/00004000/3", i, bus.rd_cmd_valid, bus.rd_cmd_addr, bus.rd_cmd_len);
      end
      step();
    end
    bus.rd_cmd_ready = 1'b1;
    step();
    checks++; if (bus.rd_cmd_valid !== 1'b0) begin errors++; $display("FAIL bp_rd_drop: got %b required 0", bus.rd_cmd_valid); end
    for (int i = 0; i < 50 && !bus.rd_done; i++) step();
    checks++; if (bus.wr_cmd_valid !== 1'b1) begin errors++; $display("FAIL bp_rddone_to_wr: got %b required 1", bus.wr_cmd_valid); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.wr_cmd_valid !== 1'b1 || bus.wr_cmd_addr !== 32'h5000 || bus.wr_cmd_len !== 4'd3) begin
        errors++; $display("FAIL bp_wr_stable: cycle %0d got v=%b addr=%h len=%0d required 1/00005000/3", i, bus.wr_cmd_valid, bus.wr_cmd_addr, bus.wr_cmd_len);
      end
      step();
    end
    bus.wr_cmd_ready = 1'b1;
    step();
    checks++; if (bus.wr_cmd_valid !== 1'b0) begin errors++; $display("FAIL bp_wr_drop: got %b required 0", bus.wr_cmd_valid); end
    for (int i = 0; i < 100 && !bus.dma_interrupt; i++) step();
    checks++; if (bus.dma_interrupt !== 1'b1 || exp_q.size() != 0) begin errors++; $display("FAIL bp_done: got irq=%b pending=%0d required 1/0", bus.dma_interrupt, exp_q.size()); end
    bus.cfg_en = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    step();
    bus.cfg_src = 32'h0000_1000;
    bus.cfg_dst = 32'h0000_2000;
    bus.cfg_len = 32'd40;
    exp_q.push_back(cmd(1'b0, 32'h1000, 4'd15));
    exp_q.push_back(cmd(1'b1, 32'h2000, 4'd15));
    bus.cfg_en = 1'b1;
    for (int i = 0; i < 100 && bus.dbg_state !== ST_WR_WAIT; i++) step();
    checks++; if (bus.dbg_state !== ST_WR_WAIT) begin errors++; $display("FAIL rmid_reach_wr_wait: got %0d required %0d", bus.dbg_state, ST_WR_WAIT); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.dma_interrupt !== 1'b0) begin errors++; $display("FAIL rmid_async_status: got busy=%b irq=%b required 0/0", bus.busy, bus.dma_interrupt); end
    checks++; if (bus.rd_cmd_valid !== 1'b0 || bus.wr_cmd_valid !== 1'b0) begin errors++; $display("FAIL rmid_async_valids: got rd=%b wr=%b required 0/0", bus.rd_cmd_valid, bus.wr_cmd_valid); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_cmds_before_reset: got %0d pending required 0", exp_q.size()); end
    bus.cfg_src = 32'h0000_8000;
    bus.cfg_dst = 32'h0000_9000;
    bus.cfg_len = 32'd20;
    exp_q.push_back(cmd(1'b0, 32'h8000, 4'd15));
    exp_q.push_back(cmd(1'b1, 32'h9000, 4'd15));
    exp_q.push_back(cmd(1'b0, 32'h8040, 4'd3));
    exp_q.push_back(cmd(1'b1, 32'h9040, 4'd3));
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 300 && !bus.dma_interrupt; i++) step();
    checks++; if (bus.dma_interrupt !== 1'b1 || exp_q.size() != 0) begin errors++; $display("FAIL rmid_rerun: got irq=%b pending=%0d required 1/0", bus.dma_interrupt, exp_q.size()); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rmid_err: got %b required 0", bus.err); end
    bus.cfg_en = 1'b0;
    step();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.cfg_en       = 1'b0;
    bus.cfg_src      = '0;
    bus.cfg_dst      = '0;
    bus.cfg_len      = '0;
    bus.rd_cmd_ready = 1'b1;
    bus.wr_cmd_ready = 1'b1;
    test_reset();
    test_copy40();
    test_4k_split();
    test_zero_len();
    test_error_abort();
    test_backpressure();
    test_reset_mid();
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
